// File: rtl/plab5_mcore_mem_net_responder.sv
// Single-stage memory responder: byte-granular reads/writes into a word array,
// with the upper half of the array reserved for the secure domain when mode=1.
module plab5_mcore_mem_net_responder #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    parameter int p_num_entries      = 256
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           mode,
    input  logic                                           req_domain,
    input  logic [p_mem_opaque_nbits+p_mem_addr_nbits+4:0] req_msg_control,
    input  logic [p_mem_data_nbits-1:0]                    req_msg_data,
    input  logic                                           req_val,
    output logic                                           req_rdy,
    output logic [p_mem_opaque_nbits+4:0]                  resp_msg_control,
    output logic [p_mem_data_nbits-1:0]                    resp_msg_data,
    output logic                                           resp_val,
    input  logic                                           resp_rdy,
    output logic                                           resp_domain,
    output logic [7:0]                                     viol_count
);
    localparam int c_idx_nbits = $clog2(p_num_entries);
    localparam int c_ctrl_msb  = p_mem_opaque_nbits + p_mem_addr_nbits + 4;

    // Handshake: a transfer happens on a cycle where val && rdy are both high.
    // The request side is ready whenever the single response slot is empty or
    // is being drained this cycle; the response holds steady until resp_rdy.
    logic [2:0]                    req_type;
    logic [p_mem_opaque_nbits-1:0] req_opaque;
    logic [p_mem_addr_nbits-1:0]   req_addr;
    logic [1:0]                    req_len;
    logic [c_idx_nbits-1:0]        idx;
    logic [1:0]                    off;
    logic [2:0]                    nbytes;
    logic                          req_go;
    logic                          blocked;
    logic                          viol_inc;
    logic                          wr_en;
    logic [p_mem_data_nbits-1:0]   rd_word;
    logic [p_mem_data_nbits-1:0]   rd_shift;
    logic [p_mem_data_nbits-1:0]   wr_shift;
    logic [p_mem_data_nbits-1:0]   rd_data;
    logic [p_mem_data_nbits-1:0]   wr_word;
    logic [p_mem_data_nbits-1:0]   resp_data_next;
    logic                          unused_addr_bits;

    logic [p_mem_data_nbits-1:0] mem [p_num_entries];

    assign req_type   = req_msg_control[c_ctrl_msb -: 3];
    assign req_opaque = req_msg_control[p_mem_addr_nbits+2 +: p_mem_opaque_nbits];
    assign req_addr   = req_msg_control[2 +: p_mem_addr_nbits];
    assign req_len    = req_msg_control[1:0];

    // Address bits above the index alias onto the same word.
    assign idx              = req_addr[2 +: c_idx_nbits];
    assign off              = req_addr[1:0];
    assign unused_addr_bits = ^req_addr[p_mem_addr_nbits-1:c_idx_nbits+2];
    assign nbytes           = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};

    assign req_rdy  = !resp_val || resp_rdy;
    assign req_go   = req_val && req_rdy && !reset;
    assign blocked  = mode && !req_domain && idx[c_idx_nbits-1];
    assign viol_inc = blocked && (req_type < 3'd2);
    assign wr_en    = (req_type == 3'd1) && !blocked;

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {off, 3'b000};
    assign wr_shift = req_msg_data << {off, 3'b000};

    always_comb begin
        rd_data = '0;
        wr_word = rd_word;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < nbytes)
                rd_data[8*j +: 8] = rd_shift[8*j +: 8];
            // Write lanes run from off upward and are clipped at the word edge.
            if ((3'(j) >= {1'b0, off}) && (3'(j) < ({1'b0, off} + nbytes)))
                wr_word[8*j +: 8] = wr_shift[8*j +: 8];
        end
    end

    assign resp_data_next = ((req_type == 3'd0) && !blocked) ? rd_data : '0;

    always_ff @(posedge clk) begin
        if (req_go && wr_en)
            mem[idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_val         <= 1'b0;
            resp_msg_control <= '0;
            resp_msg_data    <= '0;
            resp_domain      <= 1'b0;
            viol_count       <= 8'd0;
        end else begin
            if (req_go) begin
                resp_val         <= 1'b1;
                resp_msg_control <= {req_type, req_opaque, req_len};
                resp_msg_data    <= resp_data_next;
                resp_domain      <= req_domain;
                if (viol_inc && (viol_count != 8'hFF))
                    viol_count <= viol_count + 8'd1;
            end else if (resp_rdy) begin
                resp_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_plab5_mcore_mem_net_responder.sv
// Directed bench for the memory responder: a driver issues requests with
// hand-computed responses into exp_q, and a monitor checks what comes out.
module tb_plab5_mcore_mem_net_responder;

    logic        clk;
    logic        reset;
    logic        mode;
    logic        req_domain;
    logic [44:0] req_msg_control;
    logic [31:0] req_msg_data;
    logic        req_val;
    logic        req_rdy;
    logic [12:0] resp_msg_control;
    logic [31:0] resp_msg_data;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_domain;
    logic [7:0]  viol_count;

    int checks   = 0;
    int failures = 0;
    int w;
    int w_b;

    // Expected response packed as {type, opaque, len, data, domain}.
    logic [45:0] exp_q[$];

    plab5_mcore_mem_net_responder dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .req_domain       (req_domain),
        .req_msg_control  (req_msg_control),
        .req_msg_data     (req_msg_data),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .resp_msg_control (resp_msg_control),
        .resp_msg_data    (resp_msg_data),
        .resp_val         (resp_val),
        .resp_rdy         (resp_rdy),
        .resp_domain      (resp_domain),
        .viol_count       (viol_count)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Driver: present one request, wait (bounded) for the accept, push the
    // hand-computed response at the accepting edge.
    task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data, input logic dom,
                        input logic md, input logic [31:0] exp_data, output int waited);
        logic go;
        req_msg_control = {t, op, addr, len};
        req_msg_data    = data;
        req_domain      = dom;
        mode            = md;
        req_val         = 1'b1;
        waited          = 0;
        forever begin
            @(negedge clk);
            go = req_rdy;
            if (go)
                exp_q.push_back({t, op, len, exp_data, dom});
            @(posedge clk);
            if (go)
                break;
            waited++;
            if (waited > 50) begin
                failures++;
                $display("FAIL accept_timeout actual=no_accept required=accept op=0x%0h", op);
                break;
            end
        end
        #1;
        if (waited <= 50)
            check("latency_resp_val", resp_val, 1);
        req_val = 1'b0;
    endtask

    // Monitor: compare every consumed response, and require stability while stalled.
    logic        stalled = 1'b0;
    logic [46:0] held;
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_stable", {resp_val, resp_msg_control, resp_msg_data, resp_domain}, held);
            if (resp_val && resp_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual=0x%0h required=none",
                             {resp_msg_control, resp_msg_data, resp_domain});
                end else begin
                    check("resp", {resp_msg_control, resp_msg_data, resp_domain}, exp_q.pop_front());
                end
            end
            stalled = resp_val && !resp_rdy;
            held    = {resp_val, resp_msg_control, resp_msg_data, resp_domain};
        end
    end

    initial begin
        reset           = 1'b1;
        req_val         = 1'b0;
        req_msg_control = '0;
        req_msg_data    = '0;
        mode            = 1'b0;
        req_domain      = 1'b0;
        resp_rdy        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_resp_val", resp_val, 0);
        check("reset_resp_ctrl", resp_msg_control, 0);
        check("reset_resp_data", resp_msg_data, 0);
        check("reset_resp_domain", resp_domain, 0);
        check("reset_viol", viol_count, 0);
        check("reset_req_rdy", req_rdy, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic write then read back.
        send(3'd1, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, w);
        send(3'd0, 8'h02, 32'h10, 2'd0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, w);

        // Domain partition: secure word at idx 128.
        send(3'd1, 8'h03, 32'h200, 2'd0, 32'h55AA55AA, 1'b1, 1'b1, 32'h0, w);
        check("viol_after_secure_write", viol_count, 0);
        send(3'd1, 8'h04, 32'h200, 2'd0, 32'h12345678, 1'b0, 1'b1, 32'h0, w);
        check("viol_after_blocked_write", viol_count, 1);
        send(3'd0, 8'h05, 32'h200, 2'd0, 32'h0, 1'b1, 1'b1, 32'h55AA55AA, w);
        check("viol_after_secure_read", viol_count, 1);
        send(3'd0, 8'h06, 32'h200, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0, w);
        check("viol_after_blocked_read", viol_count, 2);
        send(3'd2, 8'h07, 32'h200, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0, w);
        check("viol_after_type2", viol_count, 2);

        // Partition off.
        send(3'd1, 8'h08, 32'h200, 2'd0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, w);
        send(3'd0, 8'h09, 32'h200, 2'd0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, w);
        check("viol_mode0", viol_count, 2);

        // Sub-word accesses, clipping and aliasing.
        send(3'd1, 8'h10, 32'h0, 2'd0, 32'h11223344, 1'b0, 1'b0, 32'h0, w);
        send(3'd0, 8'h11, 32'h1, 2'd1, 32'h0, 1'b0, 1'b0, 32'h00000033, w);
        send(3'd1, 8'h12, 32'h3, 2'd2, 32'h000000AB, 1'b0, 1'b0, 32'h0, w);
        send(3'd0, 8'h13, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 32'hAB223344, w);
        send(3'd0, 8'h14, 32'h2, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0000AB22, w);
        send(3'd0, 8'h15, 32'h1, 2'd2, 32'h0, 1'b0, 1'b0, 32'h00002233, w);
        send(3'd0, 8'h16, 32'h400, 2'd0, 32'h0, 1'b0, 1'b0, 32'hAB223344, w);
        send(3'd1, 8'h17, 32'h2, 2'd3, 32'h00FFEEDD, 1'b0, 1'b0, 32'h0, w);
        send(3'd0, 8'h18, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 32'hEEDD3344, w);

        // Backpressure: one accept while stalled, then full throughput.
        @(posedge clk);
        #1 resp_rdy = 1'b0;
        send(3'd0, 8'h20, 32'h10, 2'd0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, w);
        fork
            send(3'd2, 8'h21, 32'h10, 2'd1, 32'h0, 1'b1, 1'b0, 32'h0, w_b);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_req_rdy", req_rdy, 0);
                end
                @(posedge clk);
                #1 resp_rdy = 1'b1;
            end
        join
        send(3'd0, 8'h22, 32'h10, 2'd2, 32'h0, 1'b0, 1'b0, 32'h0000BEEF, w);
        check("no_bubble_c", w, 0);
        send(3'd0, 8'h23, 32'h11, 2'd0, 32'h0, 1'b1, 1'b0, 32'h00DEADBE, w);
        check("no_bubble_d", w, 0);

        // Reset with a pending response and a write presented during reset.
        @(posedge clk);
        #1 resp_rdy = 1'b0;
        send(3'd0, 8'h30, 32'h10, 2'd0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, w);
        reset = 1'b1;
        exp_q.delete();
        req_msg_control = {3'd1, 8'h31, 32'h0, 2'd0};
        req_msg_data    = 32'h99999999;
        req_val         = 1'b1;
        @(posedge clk);
        #1;
        check("rst_resp_val", resp_val, 0);
        check("rst_viol", viol_count, 0);
        check("rst_req_rdy", req_rdy, 1);
        check("rst_resp_data", resp_msg_data, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        send(3'd0, 8'h32, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 32'hEEDD3344, w);
        send(3'd0, 8'h33, 32'h10, 2'd0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, w);

        // Violation counter saturates.
        for (int i = 0; i < 260; i++)
            send(3'd0, 8'(i), 32'h204, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0, w);
        check("viol_saturate", viol_count, 255);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
